clk_div_multi: RTL

//  Multi-channel programmable clock-enable/divider generator for the car controller.

---
 rtl/clk_div_multi_if.sv | 46 ++++
 rtl/clk_div_multi.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/clk_div_multi_if.sv
// -----------------------------------------------------------------------------
// clk_div_multi_if
//   Configuration write channel for clk_div_multi.
//   A write is accepted on a rising clock edge when cfg_valid and cfg_ready are
//   both high. The accepted divisor and high time wait in a per-channel shadow
//   register until that channel reaches a period boundary.
//
//   Signals
//     cfg_valid    master->slave  write request
//     cfg_ch       master->slave  target channel (max(1, clog2(CHANNELS)) bits)
//     cfg_div      master->slave  new divisor (period in clock cycles)
//     cfg_high     master->slave  new high time in clock cycles
//     cfg_ready    slave->master  the slave can accept a write to cfg_ch
//     cfg_pending  slave->master  per-channel: shadow config not yet applied
// -----------------------------------------------------------------------------
interface clk_div_multi_if #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CNT_W    = 32
);
  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                cfg_valid;
  logic [CH_W-1:0]     cfg_ch;
  logic [CNT_W-1:0]    cfg_div;
  logic [CNT_W-1:0]    cfg_high;
  logic                cfg_ready;
  logic [CHANNELS-1:0] cfg_pending;

  modport master (
    output cfg_valid,
    output cfg_ch,
    output cfg_div,
    output cfg_high,
    input  cfg_ready,
    input  cfg_pending
  );

  modport slave (
    input  cfg_valid,
    input  cfg_ch,
    input  cfg_div,
    input  cfg_high,
    output cfg_ready,
    output cfg_pending
  );
endinterface

// File: rtl/clk_div_multi.sv
// -----------------------------------------------------------------------------
// clk_div_multi
//   Multi-channel programmable clock-enable / divider generator.
//   Each channel divides inputclock by its active divisor, drives a registered
//   divided clock that is high for the first high_act cycles of each period, and
//   pulses tick for one cycle at every period start.
//   Divisor/high-time updates go to a shadow register and are applied only at a
//   period boundary (or immediately while the channel is disabled), so a running
//   output never sees a truncated or stretched period.
//
//   Ports
//     inputclock   in   system clock, rising edge
//     rst          in   asynchronous, active-low reset
//     enable       in   per-channel run enable
//     cfg          if   configuration write channel (slave modport)
//     outputclock  out  per-channel divided clock (registered)
//     tick         out  per-channel one-cycle period-start pulse (registered)
// -----------------------------------------------------------------------------
module clk_div_multi #(
  parameter int unsigned CHANNELS    = 4,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned DEFAULT_DIV = 50
) (
  input  logic                inputclock,
  input  logic                rst,
  input  logic [CHANNELS-1:0] enable,
  clk_div_multi_if.slave      cfg,
  output logic [CHANNELS-1:0] outputclock,
  output logic [CHANNELS-1:0] tick
);

  localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] MIN_DIV  = CNT_W'(2);
  localparam logic [CNT_W-1:0] DEF_DIV  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DEF_HIGH = CNT_W'(DEFAULT_DIV / 2);

  // Active configuration and counter
  logic [CNT_W-1:0] div_act_q  [CHANNELS];
  logic [CNT_W-1:0] div_act_d  [CHANNELS];
  logic [CNT_W-1:0] high_act_q [CHANNELS];
  logic [CNT_W-1:0] high_act_d [CHANNELS];
  logic [CNT_W-1:0] cnt_q      [CHANNELS];
  logic [CNT_W-1:0] cnt_d      [CHANNELS];

  // Shadow configuration waiting for a period boundary
  logic [CNT_W-1:0] shadow_div_q  [CHANNELS];
  logic [CNT_W-1:0] shadow_div_d  [CHANNELS];
  logic [CNT_W-1:0] shadow_high_q [CHANNELS];
  logic [CNT_W-1:0] shadow_high_d [CHANNELS];
  logic [CHANNELS-1:0] pend_q;
  logic [CHANNELS-1:0] pend_d;

  // Registered outputs
  logic [CHANNELS-1:0] out_q;
  logic [CHANNELS-1:0] out_d;
  logic [CHANNELS-1:0] tick_q;
  logic [CHANNELS-1:0] tick_d;

  // Write decode
  logic [CHANNELS-1:0] wr_sel;
  logic [CNT_W-1:0]    wr_div;

  // ---------------------------------------------------------------------------
  // Config handshake. A cfg_ch that matches no channel leaves ready at 1 and
  // selects nothing, so such a write is silently dropped.
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_sel        = '0;
    cfg.cfg_ready = 1'b1;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) begin
        cfg.cfg_ready = ~pend_q[i];
        wr_sel[i]     = cfg.cfg_valid & ~pend_q[i];
      end
    end
  end

  // Divisors below 2 cannot form a period with both a tick and a wrap.
  always_comb begin
    wr_div = (cfg.cfg_div < MIN_DIV) ? MIN_DIV : cfg.cfg_div;
  end

  // ---------------------------------------------------------------------------
  // Per-channel next state
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      div_act_d[i]     = div_act_q[i];
      high_act_d[i]    = high_act_q[i];
      cnt_d[i]         = cnt_q[i];
      shadow_div_d[i]  = shadow_div_q[i];
      shadow_high_d[i] = shadow_high_q[i];
      pend_d[i]        = pend_q[i];
      out_d[i]         = 1'b0;
      tick_d[i]        = 1'b0;

      if (!enable[i]) begin
        // Park the counter on the last count so the first enabled edge wraps
        // and starts a full period with a tick.
        if (pend_q[i]) begin
          div_act_d[i]  = shadow_div_q[i];
          high_act_d[i] = shadow_high_q[i];
          pend_d[i]     = 1'b0;
          cnt_d[i]      = shadow_div_q[i] - ONE;
        end else begin
          cnt_d[i]      = div_act_q[i] - ONE;
        end
      end else if (cnt_q[i] == div_act_q[i] - ONE) begin
        // Period boundary: a pending update governs the period starting now,
        // so the output level for count 0 uses the new high time.
        cnt_d[i]  = '0;
        tick_d[i] = 1'b1;
        if (pend_q[i]) begin
          div_act_d[i]  = shadow_div_q[i];
          high_act_d[i] = shadow_high_q[i];
          pend_d[i]     = 1'b0;
          out_d[i]      = (shadow_high_q[i] != '0);
        end else begin
          out_d[i]      = (high_act_q[i] != '0);
        end
      end else begin
        cnt_d[i] = cnt_q[i] + ONE;
        out_d[i] = ((cnt_q[i] + ONE) < high_act_q[i]);
      end

      // A write is only selected when pend_q is clear, so it never collides
      // with an apply on the same channel.
      if (wr_sel[i]) begin
        shadow_div_d[i]  = wr_div;
        shadow_high_d[i] = cfg.cfg_high;
        pend_d[i]        = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge inputclock or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        div_act_q[i]     <= DEF_DIV;
        high_act_q[i]    <= DEF_HIGH;
        cnt_q[i]         <= DEF_DIV - ONE;
        shadow_div_q[i]  <= DEF_DIV;
        shadow_high_q[i] <= DEF_HIGH;
      end
      pend_q <= '0;
      out_q  <= '0;
      tick_q <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        div_act_q[i]     <= div_act_d[i];
        high_act_q[i]    <= high_act_d[i];
        cnt_q[i]         <= cnt_d[i];
        shadow_div_q[i]  <= shadow_div_d[i];
        shadow_high_q[i] <= shadow_high_d[i];
      end
      pend_q <= pend_d;
      out_q  <= out_d;
      tick_q <= tick_d;
    end
  end

  assign cfg.cfg_pending = pend_q;
  assign outputclock     = out_q;
  assign tick            = tick_q;

endmodule
